// File: rtl/exec_step_ctrl_pkg.sv
// Shared types and constants for the execution-control stage.
// State encoding and syscall service numbers used by the core front end.
package exec_step_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        STEP = 2'd2
    } exec_state_t;

    // Syscall service number ($v0) that requests a print and must not halt the core.
    localparam int unsigned PRINT_SERVICE = 34;

    function automatic logic is_print_service(input logic [31:0] v0);
        return v0 == 32'(PRINT_SERVICE);
    endfunction

    function automatic logic stop_request(input logic syscall, input logic print_irq);
        return syscall & ~print_irq;
    endfunction

endpackage

// File: rtl/exec_step_ctrl_if.sv
// Control bundle between the core front end and the execution-control stage.
// master = core/board side, slave = exec_step_ctrl.
interface exec_step_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             go_btn;
    logic             run_mode;
    logic             syscall;
    logic             print_irq;
    logic             pc_en;
    logic             halted;
    logic             go_pulse;
    logic [CNT_W-1:0] retired;

    modport master (
        output go_btn, run_mode, syscall, print_irq,
        input  pc_en, halted, go_pulse, retired
    );

    modport slave (
        input  go_btn, run_mode, syscall, print_irq,
        output pc_en, halted, go_pulse, retired
    );
endinterface

// File: rtl/exec_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          go_s;
    logic [CW-1:0] cnt_q;
    logic          go_db_q;
    logic          go_db_d1_q;
    logic          pulse_q;

    assign go_s = sync_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            go_db_q <= 1'b0;
        end else if (go_s == go_db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            go_db_q <= go_s;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            go_db_d1_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            go_db_d1_q <= go_db_q;
            pulse_q    <= go_db_q & ~go_db_d1_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/exec_step_ctrl.sv
// Execution control for the single-cycle core: RUN/HALT/STEP sequencing of the
// PC enable, GO button conditioning and a retired-instruction counter.
module exec_step_ctrl
    import exec_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 32,
    parameter bit          START_RUN       = 1'b1
) (
    input logic             clk,
    input logic             rst,
    exec_step_ctrl_if.slave bus
);
    localparam exec_state_t RESET_STATE = START_RUN ? RUN : HALT;

    exec_state_t      state_q;
    exec_state_t      state_nxt;
    logic             stop_req;
    logic             pc_en;
    logic             go_pulse;
    logic             halted_q;
    logic [CNT_W-1:0] retired_q;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_go_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.go_btn),
        .pulse (go_pulse)
    );

    assign stop_req = stop_request(bus.syscall, bus.print_irq);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // A halting syscall beats single-step mode; GO is only honoured from HALT.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            RUN: begin
                if (stop_req || !bus.run_mode) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (go_pulse) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                state_nxt = bus.run_mode ? RUN : HALT;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // STEP commits unconditionally so the halting syscall itself retires.
    always_comb begin
        pc_en = 1'b0;
        case (state_q)
            RUN:     pc_en = ~stop_req;
            HALT:    pc_en = 1'b0;
            STEP:    pc_en = 1'b1;
            default: pc_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= ~START_RUN;
        end else begin
            halted_q <= (state_nxt == HALT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.pc_en    = pc_en;
    assign bus.halted   = halted_q;
    assign bus.go_pulse = go_pulse;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_exec_step_ctrl.sv
// Self-checking bench for exec_step_ctrl: directed scenarios plus random
// stimulus compared against a behavioural model of the control rules.
module tb_exec_step_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;
    logic go_btn;
    logic run_mode;
    logic syscall;
    logic print_irq;

    int n_tests = 0;
    int n_fail  = 0;

    exec_step_ctrl_if #(.CNT_W(CW)) bus0 ();
    exec_step_ctrl_if #(.CNT_W(CW)) bus1 ();

    assign bus0.go_btn    = go_btn;
    assign bus0.run_mode  = run_mode;
    assign bus0.syscall   = syscall;
    assign bus0.print_irq = print_irq;
    assign bus1.go_btn    = go_btn;
    assign bus1.run_mode  = run_mode;
    assign bus1.syscall   = syscall;
    assign bus1.print_irq = print_irq;

    exec_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .START_RUN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    exec_step_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(CW), .START_RUN(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of dut0 (START_RUN=1).
    logic          m_b1, m_b2, m_db, m_rose, m_pulse, m_halted, m_step;
    logic [DB-2:0] m_win;
    logic [DB-1:0] win_n;
    logic          db_n;
    logic [CW-1:0] m_ret;

    // Debounced level flips once the last DB synchronized samples all disagree with it.
    assign win_n = {m_win, m_b2};
    assign db_n  = (win_n == {DB{~m_db}}) ? ~m_db : m_db;

    function automatic logic m_pc_en();
        return m_step | (~m_halted & ~(syscall & ~print_irq));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_b1 <= 1'b0; m_b2 <= 1'b0; m_win <= '0; m_db <= 1'b0;
            m_rose <= 1'b0; m_pulse <= 1'b0;
            m_halted <= 1'b0; m_step <= 1'b0; m_ret <= '0;
        end else begin
            m_b1    <= go_btn;
            m_b2    <= m_b1;
            m_win   <= win_n[DB-2:0];
            m_db    <= db_n;
            m_rose  <= db_n & ~m_db;
            m_pulse <= m_rose;
            m_ret   <= m_ret + CW'(m_pc_en());
            if (m_step) begin
                m_step   <= 1'b0;
                m_halted <= ~run_mode;
            end else if (m_halted) begin
                if (m_pulse) begin
                    m_step   <= 1'b1;
                    m_halted <= 1'b0;
                end
            end else if ((syscall & ~print_irq) || !run_mode) begin
                m_halted <= 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (bus0.retired !== 8'd0) begin n_fail++; $display("FAIL rst_retired0: got %0d want 0", bus0.retired); end
        n_tests++; if (bus0.go_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_pulse0: got %b want 0", bus0.go_pulse); end
        n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted0: got %b want 0", bus0.halted); end
        n_tests++; if (bus1.halted !== 1'b1) begin n_fail++; $display("FAIL rst_halted1: got %b want 1", bus1.halted); end
        n_tests++; if (bus1.pc_en !== 1'b0) begin n_fail++; $display("FAIL rst_pc_en1: got %b want 0", bus1.pc_en); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            n_tests++; if (bus0.pc_en !== 1'b1) begin n_fail++; $display("FAIL run_pc_en cyc %0d: got %b want 1", i, bus0.pc_en); end
            cyc();
        end
        #1;
        n_tests++; if (bus0.retired !== 8'd100) begin n_fail++; $display("FAIL run_retired100: got %0d want 100", bus0.retired); end
        n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL run_halted: got %b want 0", bus0.halted); end
        n_tests++; if (bus1.halted !== 1'b1) begin n_fail++; $display("FAIL halt_start_halted1: got %b want 1", bus1.halted); end
        n_tests++; if (bus1.retired !== 8'd0) begin n_fail++; $display("FAIL halt_start_retired1: got %0d want 0", bus1.retired); end
    endtask

    task automatic test_debounce();
        int k;
        for (int i = 0; i < 20; i++) begin
            cyc();
            go_btn = ((i / 2) % 2 == 0);
            #1;
            n_tests++; if (bus0.go_pulse !== 1'b0) begin n_fail++; $display("FAIL bounce_pulse cyc %0d: got %b want 0", i, bus0.go_pulse); end
        end
        cyc();
        go_btn = 1'b1;
        for (k = 1; k <= 30; k++) begin
            cyc();
            #1;
            if (bus0.go_pulse === 1'b1) break;
        end
        n_tests++; if (k != DB + 3) begin n_fail++; $display("FAIL pulse_latency: got %0d want %0d", k, DB + 3); end
        n_tests++; if (m_pulse !== 1'b1) begin n_fail++; $display("FAIL pulse_model: got %b want 1", m_pulse); end
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            n_tests++; if (bus0.go_pulse !== 1'b0) begin n_fail++; $display("FAIL held_pulse cyc %0d: got %b want 0", i, bus0.go_pulse); end
        end
        go_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            #1;
            n_tests++; if (bus0.go_pulse !== 1'b0) begin n_fail++; $display("FAIL release_pulse cyc %0d: got %b want 0", i, bus0.go_pulse); end
        end
    endtask

    task automatic test_syscall_halt();
        logic [CW-1:0] r0;
        int k;
        run_mode = 1'b1; syscall = 1'b1; print_irq = 1'b0;
        #1;
        r0 = m_ret;
        n_tests++; if (bus0.pc_en !== 1'b0) begin n_fail++; $display("FAIL stop_pc_en: got %b want 0", bus0.pc_en); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            n_tests++; if (bus0.halted !== 1'b1) begin n_fail++; $display("FAIL stop_halted cyc %0d: got %b want 1", i, bus0.halted); end
            n_tests++; if (bus0.retired !== r0) begin n_fail++; $display("FAIL stop_retired cyc %0d: got %0d want %0d", i, bus0.retired, r0); end
        end
        go_btn = 1'b1;
        for (k = 1; k <= 30; k++) begin
            cyc();
            #1;
            if (bus0.pc_en === 1'b1) break;
        end
        n_tests++; if (k != DB + 4) begin n_fail++; $display("FAIL step_latency: got %0d want %0d", k, DB + 4); end
        n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL step_halted: got %b want 0", bus0.halted); end
        cyc();
        syscall = 1'b0; go_btn = 1'b0;
        #1;
        n_tests++; if (bus0.retired !== CW'(r0 + 8'd1)) begin n_fail++; $display("FAIL step_retired: got %0d want %0d", bus0.retired, CW'(r0 + 8'd1)); end
        n_tests++; if (bus0.pc_en !== 1'b1) begin n_fail++; $display("FAIL resume_pc_en: got %b want 1", bus0.pc_en); end
        n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL resume_halted: got %b want 0", bus0.halted); end
        repeat (10) cyc();
    endtask

    task automatic test_print();
        logic [CW-1:0] r0;
        r0 = m_ret;
        syscall = 1'b1; print_irq = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (i == 10) syscall = 1'b0;
            #1;
            n_tests++; if (bus0.pc_en !== 1'b1) begin n_fail++; $display("FAIL print_pc_en cyc %0d: got %b want 1", i, bus0.pc_en); end
            cyc();
            n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL print_halted cyc %0d: got %b want 0", i, bus0.halted); end
        end
        #1;
        n_tests++; if (bus0.retired !== CW'(r0 + 8'd15)) begin n_fail++; $display("FAIL print_retired: got %0d want %0d", bus0.retired, CW'(r0 + 8'd15)); end
        print_irq = 1'b0;
    endtask

    task automatic test_single_step();
        logic [CW-1:0] r0;
        int n_pe;
        logic prev;
        run_mode = 1'b0;
        #1;
        r0 = m_ret;
        n_tests++; if (bus0.pc_en !== 1'b1) begin n_fail++; $display("FAIL ss_commit: got %b want 1", bus0.pc_en); end
        cyc();
        #1;
        n_tests++; if (bus0.halted !== 1'b1) begin n_fail++; $display("FAIL ss_halt: got %b want 1", bus0.halted); end
        n_pe = 0;
        prev = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 2 * (DB + 6); j++) begin
                go_btn = (j < DB + 6);
                cyc();
                #1;
                n_tests++; if (bus0.pc_en !== m_pc_en()) begin n_fail++; $display("FAIL ss_pc_en press %0d cyc %0d: got %b want %b", p, j, bus0.pc_en, m_pc_en()); end
                n_tests++; if (bus0.pc_en === 1'b1 && prev === 1'b1) begin n_fail++; $display("FAIL ss_isolated press %0d cyc %0d: got 2 adjacent want 1", p, j); end
                if (bus0.pc_en === 1'b1) n_pe++;
                prev = bus0.pc_en;
            end
            n_tests++; if (bus0.halted !== 1'b1) begin n_fail++; $display("FAIL ss_between press %0d: got %b want 1", p, bus0.halted); end
        end
        n_tests++; if (n_pe != 3) begin n_fail++; $display("FAIL ss_count: got %0d want 3", n_pe); end
        n_tests++; if (bus0.retired !== CW'(r0 + 8'd4)) begin n_fail++; $display("FAIL ss_retired: got %0d want %0d", bus0.retired, CW'(r0 + 8'd4)); end
    endtask

    task automatic test_reset_step();
        int k;
        go_btn = 1'b1;
        for (k = 1; k <= 30; k++) begin
            cyc();
            #1;
            if (bus0.pc_en === 1'b1) break;
        end
        n_tests++; if (k != DB + 4) begin n_fail++; $display("FAIL rs_step_latency: got %0d want %0d", k, DB + 4); end
        go_btn = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        n_tests++; if (bus0.retired !== 8'd0) begin n_fail++; $display("FAIL rs_retired0: got %0d want 0", bus0.retired); end
        n_tests++; if (bus0.halted !== 1'b0) begin n_fail++; $display("FAIL rs_halted0: got %b want 0", bus0.halted); end
        n_tests++; if (bus0.go_pulse !== 1'b0) begin n_fail++; $display("FAIL rs_pulse0: got %b want 0", bus0.go_pulse); end
        n_tests++; if (bus1.halted !== 1'b1) begin n_fail++; $display("FAIL rs_halted1: got %b want 1", bus1.halted); end
        n_tests++; if (bus1.pc_en !== 1'b0) begin n_fail++; $display("FAIL rs_pc_en1: got %b want 0", bus1.pc_en); end
        n_tests++; if (bus1.retired !== 8'd0) begin n_fail++; $display("FAIL rs_retired1: got %0d want 0", bus1.retired); end
        cyc();
        n_tests++; if (bus0.retired !== 8'd0) begin n_fail++; $display("FAIL rs_hold_retired0: got %0d want 0", bus0.retired); end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            #1;
            n_tests++; if (bus1.pc_en !== 1'b0) begin n_fail++; $display("FAIL rs_post_pc_en1 cyc %0d: got %b want 0", i, bus1.pc_en); end
            n_tests++; if (bus1.halted !== 1'b1) begin n_fail++; $display("FAIL rs_post_halted1 cyc %0d: got %b want 1", i, bus1.halted); end
            n_tests++; if (bus0.pc_en !== m_pc_en()) begin n_fail++; $display("FAIL rs_post_pc_en0 cyc %0d: got %b want %b", i, bus0.pc_en, m_pc_en()); end
        end
    endtask

    task automatic test_wrap();
        run_mode = 1'b1;
        go_btn = 1'b1;
        repeat (DB + 6) cyc();
        go_btn = 1'b0;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (m_ret == 8'hFF) break;
            cyc();
        end
        n_tests++; if (bus0.retired !== 8'hFF) begin n_fail++; $display("FAIL wrap_full: got %0d want 255", bus0.retired); end
        n_tests++; if (bus0.pc_en !== 1'b1) begin n_fail++; $display("FAIL wrap_pc_en: got %b want 1", bus0.pc_en); end
        cyc();
        #1;
        n_tests++; if (bus0.retired !== 8'h00) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", bus0.retired); end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            cyc();
            if ($urandom_range(0, 19) == 0) run_mode = 1'($urandom);
            syscall   = ($urandom_range(0, 3) == 0);
            print_irq = 1'($urandom);
            if (hold == 0) begin
                go_btn = ~go_btn;
                hold = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(DB + 2, DB + 12));
            end else begin
                hold--;
            end
            #1;
            n_tests++; if (bus0.pc_en !== m_pc_en()) begin n_fail++; $display("FAIL rnd_pc_en cyc %0d: got %b want %b", i, bus0.pc_en, m_pc_en()); end
            n_tests++; if (bus0.halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted cyc %0d: got %b want %b", i, bus0.halted, m_halted); end
            n_tests++; if (bus0.go_pulse !== m_pulse) begin n_fail++; $display("FAIL rnd_pulse cyc %0d: got %b want %b", i, bus0.go_pulse, m_pulse); end
            n_tests++; if (bus0.retired !== m_ret) begin n_fail++; $display("FAIL rnd_retired cyc %0d: got %0d want %0d", i, bus0.retired, m_ret); end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        go_btn = 1'b0; run_mode = 1'b1; syscall = 1'b0; print_irq = 1'b0;
        #1;
        rst = 1'b0;
        test_reset();
        test_debounce();
        test_syscall_halt();
        test_print();
        test_single_step();
        test_reset_step();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
